// File: rtl/sqrt_sweep_if.sv
// Bus between the sweep sequencer, the N-value memory, the sqrt core and the result/display side.
interface sqrt_sweep_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              go;
  logic              step_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              sq_st;
  logic [7:0]        sq_n;
  logic              sq_done;
  logic [3:0]        sq_root;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_n;
  logic [3:0]        res_root;
  logic              busy;
  logic              sweep_done;
  logic              timeout_err;

  modport master (
    input  go, step_en, mem_data, sq_done, sq_root,
    output mem_addr, sq_st, sq_n, res_valid, res_addr, res_n, res_root,
           busy, sweep_done, timeout_err
  );

  modport slave (
    output go, step_en, mem_data, sq_done, sq_root,
    input  mem_addr, sq_st, sq_n, res_valid, res_addr, res_n, res_root,
           busy, sweep_done, timeout_err
  );
endinterface

// File: rtl/sqrt_sweep_ctrl.sv
// Sequencer walking the N-value memory through the iterative sqrt unit, one result beat per word.
// Define SQRT_SWEEP_LOOP_EN for continuous sweeping with go-while-busy as a stop request.
module sqrt_sweep_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned LAST_ADDR   = 15,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  sqrt_sweep_if.master  bus
);
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_EMIT, S_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              sq_st_q, sq_st_d;
  logic [7:0]        sq_n_q, sq_n_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [7:0]        res_n_q, res_n_d;
  logic [3:0]        res_root_q, res_root_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic              timeout_err_q, timeout_err_d;
`ifdef SQRT_SWEEP_LOOP_EN
  logic              stop_q, stop_d;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    sq_n_d        = sq_n_q;
    res_addr_d    = res_addr_q;
    res_n_d       = res_n_q;
    res_root_d    = res_root_q;
    timeout_err_d = timeout_err_q;
`ifdef SQRT_SWEEP_LOOP_EN
    stop_d        = stop_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          state_d       = S_FETCH;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
`ifdef SQRT_SWEEP_LOOP_EN
          stop_d        = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sq_n_d  = bus.mem_data;
        state_d = S_START;
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO, S_WAIT_HI: begin
        // A done seen in WAIT_LO only acknowledges the start; a real result needs WAIT_HI.
        if (state_q == S_WAIT_HI && bus.sq_done) begin
          res_addr_d = cnt_q;
          res_n_d    = sq_n_q;
          res_root_d = bus.sq_root;
          state_d    = S_EMIT;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (state_q == S_WAIT_LO && !bus.sq_done) state_d = S_WAIT_HI;
        end
      end
      S_EMIT: state_d = S_HOLD;
      S_HOLD: begin
        if (bus.step_en) begin
`ifdef SQRT_SWEEP_LOOP_EN
          if (stop_q || bus.go) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = (cnt_q == ADDR_W'(LAST_ADDR)) ? '0 : cnt_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
`else
          if (cnt_q == ADDR_W'(LAST_ADDR)) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SQRT_SWEEP_LOOP_EN
    if (!(state_q inside {S_IDLE, S_DONE}) && bus.go) stop_d = 1'b1;
`endif
    mem_addr_d   = (state_d == S_FETCH) ? cnt_d : mem_addr_q;
    sq_st_d      = (state_d == S_START);
    res_valid_d  = (state_d == S_EMIT);
    busy_d       = !(state_d inside {S_IDLE, S_DONE});
    sweep_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      mem_addr_q    <= '0;
      sq_st_q       <= 1'b0;
      sq_n_q        <= '0;
      res_valid_q   <= 1'b0;
      res_addr_q    <= '0;
      res_n_q       <= '0;
      res_root_q    <= '0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef SQRT_SWEEP_LOOP_EN
      stop_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      mem_addr_q    <= mem_addr_d;
      sq_st_q       <= sq_st_d;
      sq_n_q        <= sq_n_d;
      res_valid_q   <= res_valid_d;
      res_addr_q    <= res_addr_d;
      res_n_q       <= res_n_d;
      res_root_q    <= res_root_d;
      busy_q        <= busy_d;
      sweep_done_q  <= sweep_done_d;
      timeout_err_q <= timeout_err_d;
`ifdef SQRT_SWEEP_LOOP_EN
      stop_q        <= stop_d;
`endif
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.sq_st       = sq_st_q;
  assign bus.sq_n        = sq_n_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_addr    = res_addr_q;
  assign bus.res_n       = res_n_q;
  assign bus.res_root    = res_root_q;
  assign bus.busy        = busy_q;
  assign bus.sweep_done  = sweep_done_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_sqrt_sweep_ctrl.sv
// Bench for sqrt_sweep_ctrl: registered-read memory, sqrt unit with configurable latency/stale done,
// and a timeline reference of the sweep compared against every output on every cycle.
module tb_sqrt_sweep_ctrl;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned LAST_ADDR   = 15;
  localparam int          TIMEOUT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go_r = 1'b0;
  logic       step_r = 1'b1;
  logic [7:0] mem_r = 8'd0;
  logic       done_r = 1'b1;
  logic [3:0] root_r = 4'd0;

  always #5 clk = ~clk;

  sqrt_sweep_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.go       = go_r;
  assign bus.step_en  = step_r;
  assign bus.mem_data = mem_r;
  assign bus.sq_done  = done_r;
  assign bus.sq_root  = root_r;

  sqrt_sweep_ctrl #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- environment: memory and sqrt unit ----------------
  logic [7:0] rom [16];
  int  lat_fixed = 0;
  int  stale_cyc = 0;
  int  hang_addr = 16;
  logic [7:0] env_n = 8'd0;
  int  env_lat = 0;
  int  env_stale = 0;
  bit  env_hang = 1'b0;

  always @(posedge clk) mem_r <= rom[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.sq_st) begin
      env_n     <= bus.sq_n;
      env_lat   <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 10));
      env_stale <= stale_cyc;
      env_hang  <= (int'(bus.mem_addr) == hang_addr);
      if (stale_cyc == 0) done_r <= 1'b0;
    end else if (env_stale != 0) begin
      env_stale <= env_stale - 1;
      if (env_stale == 1) done_r <= 1'b0;
    end else if (!done_r && !env_hang) begin
      if (env_lat <= 1) begin
        done_r <= 1'b1;
        root_r <= 4'(isqrt(int'(env_n)));
      end else begin
        env_lat <= env_lat - 1;
      end
    end
  end

  // ---------------- reference: the sweep as a timeline of clock edges ----------------
  logic [3:0] e_mem_addr, e_res_addr, e_res_root;
  logic [7:0] e_sq_n, e_res_n;
  logic       e_sq_st, e_res_valid, e_busy, e_done, e_timeout;
  bit         m_stop;

  task automatic reset_exp();
    e_mem_addr = 0; e_res_addr = 0; e_res_root = 0; e_sq_n = 0; e_res_n = 0;
    e_sq_st = 0; e_res_valid = 0; e_busy = 0; e_done = 0; e_timeout = 0;
  endtask

  task automatic adv(output bit r);
    @(posedge clk);
    r = rst;
    if (!rst && go_r) m_stop = 1'b1;
  endtask

  initial begin : model
    bit r, low, got, fin;
    int a, t;
    reset_exp();
    forever begin
      adv(r);
      if (r) begin reset_exp(); continue; end
      if (!go_r) continue;
      e_busy = 1; e_done = 0; e_timeout = 0; a = 0; m_stop = 0; fin = 0;
      while (!fin) begin
        e_mem_addr = 4'(a);
        adv(r); if (r) break;
        adv(r); if (r) break;
        e_sq_st = 1; e_sq_n = rom[a];
        adv(r); if (r) break;
        e_sq_st = 0; t = 0; low = 0; got = 0;
        while (1) begin
          adv(r); if (r) break;
          t++;
          if (low && done_r) begin got = 1; break; end
          if (!done_r) low = 1;
          if (t == TIMEOUT_CYC) break;
        end
        if (r) break;
        if (!got) begin
          e_busy = 0; e_done = 1; e_timeout = 1; fin = 1;
        end else begin
          e_res_valid = 1; e_res_addr = 4'(a); e_res_n = rom[a];
          e_res_root = 4'(isqrt(int'(rom[a])));
          adv(r); if (r) break;
          e_res_valid = 0;
          do adv(r); while (!r && !step_r);
          if (r) break;
`ifdef SQRT_SWEEP_LOOP_EN
          if (m_stop) fin = 1;
          else a = (a == int'(LAST_ADDR)) ? 0 : a + 1;
`else
          if (a == int'(LAST_ADDR)) fin = 1;
          else a++;
`endif
          if (fin) begin e_busy = 0; e_done = 1; end
        end
      end
      if (r) reset_exp();
    end
  end

  // ---------------- per-cycle compare and bookkeeping ----------------
  bit cmp_en = 1'b0;
  int st_count = 0;
  int beat_addr[$];
  int beat_root[$];

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_addr", int'(bus.mem_addr), int'(e_mem_addr));
      chk("sq_st", int'(bus.sq_st), int'(e_sq_st));
      chk("sq_n", int'(bus.sq_n), int'(e_sq_n));
      chk("res_valid", int'(bus.res_valid), int'(e_res_valid));
      chk("res_addr", int'(bus.res_addr), int'(e_res_addr));
      chk("res_n", int'(bus.res_n), int'(e_res_n));
      chk("res_root", int'(bus.res_root), int'(e_res_root));
      chk("busy", int'(bus.busy), int'(e_busy));
      chk("sweep_done", int'(bus.sweep_done), int'(e_done));
      chk("timeout_err", int'(bus.timeout_err), int'(e_timeout));
      if (bus.sq_st) st_count++;
      if (bus.res_valid) begin
        beat_addr.push_back(int'(bus.res_addr));
        beat_root.push_back(int'(bus.res_root));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_go();
    go_r = 1'b1;
    @(negedge clk);
    go_r = 1'b0;
  endtask

  task automatic clear_log();
    st_count = 0;
    beat_addr.delete();
    beat_root.delete();
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while (!bus.sweep_done && i < 3000) begin @(negedge clk); i++; end
    chk(nm, int'(bus.sweep_done), 1);
  endtask

  task automatic finish_sweep(input string nm);
`ifdef SQRT_SWEEP_LOOP_EN
    int i = 0;
    while (beat_addr.size() < 18 && !bus.sweep_done && i < 3000) begin @(negedge clk); i++; end
    if (!bus.sweep_done) pulse_go();
`endif
    wait_done(nm);
  endtask

  // ---------------- tests ----------------
  initial begin
    int k;
    rom[0] = 8'd0; rom[1] = 8'd1; rom[2] = 8'd4; rom[3] = 8'd15; rom[4] = 8'd16; rom[5] = 8'd255;
    for (int i = 6; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));

    // 1: reset, then idle
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(5);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_sweep_done", int'(bus.sweep_done), 0);

    // 2: full sweep, random latency, free-run
    clear_log();
    pulse_go();
    k = 0;
    while (!bus.sq_st && k < 10) begin @(negedge clk); k++; end
    chk("go_to_first_st", k, 2);
    finish_sweep("sweep2_done");
    chk("sweep2_busy", int'(bus.busy), 0);
    if (beat_root.size() >= 6) begin
      chk("root_addr2", beat_root[2], 2);
      chk("root_addr3", beat_root[3], 3);
      chk("root_addr4", beat_root[4], 4);
      chk("root_addr5", beat_root[5], 15);
    end else chk("sweep2_beats_min", beat_root.size(), 16);
`ifdef SQRT_SWEEP_LOOP_EN
    if (beat_addr.size() > 16) chk("loop_wrap_addr", beat_addr[16], 0);
    else chk("loop_beats_min", beat_addr.size(), 17);
    chk("loop_st_vs_beats", st_count, beat_addr.size());
`else
    chk("sweep2_beats", beat_addr.size(), 16);
    chk("sweep2_st_pulses", st_count, 16);
    if (beat_addr.size() == 16) chk("sweep2_last_addr", beat_addr[15], 15);
`endif

    // 3: step_en held low after first EMIT, then random stepping
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    clear_log();
    pulse_go();
    k = 0;
    while (!bus.res_valid && k < 200) begin @(negedge clk); k++; end
    chk("first_emit_seen", int'(bus.res_valid), 1);
    step_r = 1'b0;
    cycles(20);
    chk("hold_no_st", st_count, 1);
    chk("hold_no_beat", beat_addr.size(), 1);
    step_r = 1'b1;
    @(negedge clk);
    chk("after_hold_addr", int'(bus.mem_addr), 1);
    for (int i = 0; i < 150; i++) begin
      step_r = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    step_r = 1'b1;
    finish_sweep("sweep3_done");

    // 4: sqrt never finishes on addr 3 -> timeout abort
    clear_log();
    hang_addr = 3;
    pulse_go();
    wait_done("timeout_done");
    chk("timeout_flag", int'(bus.timeout_err), 1);
    chk("timeout_beats", beat_addr.size(), 3);
    hang_addr = 16;
    pulse_go();
    chk("go_clears_timeout", int'(bus.timeout_err), 0);
    chk("go_restarts_busy", int'(bus.busy), 1);
    finish_sweep("after_timeout_done");
    chk("after_timeout_flag", int'(bus.timeout_err), 0);

    // 5: stale done held after start; go while busy
    clear_log();
    stale_cyc = 2;
    pulse_go();
`ifndef SQRT_SWEEP_LOOP_EN
    cycles(30);
    pulse_go();
    cycles(100);
    pulse_go();
`endif
    finish_sweep("stale_done");
`ifndef SQRT_SWEEP_LOOP_EN
    chk("stale_beats", beat_addr.size(), 16);
`endif
    stale_cyc = 0;

    // 6: reset during WAIT_HI of addr 7
    clear_log();
    lat_fixed = 10;
    pulse_go();
    k = 0;
    while (!(bus.sq_st && bus.mem_addr == 4'd7) && k < 1000) begin @(negedge clk); k++; end
    chk("reach_addr7_start", int'(bus.sq_st), 1);
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sq_st", int'(bus.sq_st), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_beats", beat_addr.size(), 7);
    cycles(20);
    chk("rst_stays_idle", int'(bus.busy), 0);
    lat_fixed = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
